// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the flattened-butterfly router.
// Holds flit field offsets, coordinate-width helpers, the FSM state type
// and the dimension-order output-port function used by the input unit
// and by the NoC top-level wiring checks.
package fb_pkg;

  localparam int unsigned HEAD_BIT = 0;
  localparam int unsigned TAIL_BIT = 1;
  localparam int unsigned DEST_OFS = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } fb_state_e;

  // Width of an index over n items, never less than one bit.
  function automatic int unsigned fb_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned fb_d0w(input int unsigned node_per_row);
    return fb_clog2(node_per_row);
  endfunction

  function automatic int unsigned fb_d1w(input int unsigned node_per_col);
    return fb_clog2(node_per_col);
  endfunction

  // Dimension-order output port: dim0 links first, then dim1 links, then local.
  // Own coordinate is skipped in each dimension, hence the -1/-2 offsets.
  function automatic int unsigned fb_port_idx(
    input int unsigned dest0,
    input int unsigned dest1,
    input int unsigned i,
    input int unsigned j,
    input int unsigned node_per_row,
    input int unsigned node_per_col
  );
    if (dest0 != i) begin
      return (dest0 < i) ? dest0 : dest0 - 1;
    end else if (dest1 != j) begin
      return (dest1 < j) ? dest1 + node_per_row - 1 : dest1 + node_per_row - 2;
    end else begin
      return node_per_row + node_per_col - 2;
    end
  endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// fb_sync_fifo: synchronous flit FIFO with a registered head entry.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_push, i_data  write request and flit; ignored when full unless popping
//   i_pop           read request; ignored when empty
//   o_full_c        buffer full (decoded from the occupancy register)
//   o_empty_c       buffer empty (decoded from the occupancy register)
//   o_count_nxt_c   occupancy after this cycle's push/pop
//   o_head          registered head flit, zero when empty
module fb_sync_fifo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [0:DATA_W-1]            i_data,
  input  logic                         i_pop,
  output logic                         o_full_c,
  output logic                         o_empty_c,
  output logic [$clog2(FIFO_DEPTH):0]  o_count_nxt_c,
  output logic [0:DATA_W-1]            o_head
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [0:DATA_W-1] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [0:DATA_W-1] r_head;

  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [PTR_W-1:0]  w_wr_nxt;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [0:DATA_W-1] w_head_nxt;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // Next pointers, occupancy and head entry.
  always_comb begin
    w_pop_ok    = i_pop && !w_empty;
    w_push_ok   = i_push && (!w_full || w_pop_ok);
    w_wr_nxt    = r_wr_ptr + PTR_W'(w_push_ok);
    w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop_ok);
    w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    w_head_nxt  = r_mem[w_rd_nxt];
    if (w_count_nxt == '0) begin
      w_head_nxt = '0;
    end else if (w_push_ok && (w_rd_nxt == r_wr_ptr)) begin
      // The next head is the flit being written right now: bypass the array.
      w_head_nxt = i_data;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_full_c      = w_full;
  assign o_empty_c     = w_empty;
  assign o_count_nxt_c = w_count_nxt;
  assign o_head        = r_head;

endmodule

// File: rtl/fb_input_unit.sv
// fb_input_unit: router input port with wormhole buffering, hysteresis
// flow control, per-packet dimension-order routing and sticky error flags.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   valid_i      upstream flit valid
//   data_i       upstream flit (bit 0 head, bit 1 tail, then dest dim0/dim1)
//   off_o        flow control to upstream, 1 = stop sending
//   req_o        one-hot output-port request to the switch allocator
//   flit_o       flit at the buffer head
//   grant_i      switch grant, pops the head flit while req_o is non-zero
//   overflow_o   sticky: flit arrived while full with no pop
//   proto_err_o  sticky: non-head flit found at the head while idle
module fb_input_unit #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned OFF_THRESH   = 6,
  parameter int unsigned ON_THRESH    = 3,
  parameter int unsigned NODE_PER_ROW = 4,
  parameter int unsigned NODE_PER_COL = 4,
  parameter int unsigned curr_dim0    = 0,
  parameter int unsigned curr_dim1    = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_i,
  input  logic [0:DATA_W-1]                    data_i,
  output logic                                 off_o,
  output logic [0:NODE_PER_ROW+NODE_PER_COL-2] req_o,
  output logic [0:DATA_W-1]                    flit_o,
  input  logic                                 grant_i,
  output logic                                 overflow_o,
  output logic                                 proto_err_o
);

  import fb_pkg::*;

  localparam int unsigned OUTPORT = NODE_PER_ROW + NODE_PER_COL - 1;
  localparam int unsigned D0W     = fb_d0w(NODE_PER_ROW);
  localparam int unsigned D1W     = fb_d1w(NODE_PER_COL);
  localparam int unsigned ROUTE_W = fb_clog2(OUTPORT);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  fb_state_e           r_state;
  fb_state_e           w_state_nxt;
  logic [ROUTE_W-1:0]  r_route;
  logic [ROUTE_W-1:0]  w_route_nxt;
  logic [ROUTE_W-1:0]  w_route_calc;
  logic [0:OUTPORT-1]  r_req;
  logic [0:OUTPORT-1]  w_req_nxt;
  logic                r_off;
  logic                w_off_nxt;
  logic                r_ovf;
  logic                w_ovf_nxt;
  logic                r_perr;
  logic                w_perr_nxt;
  logic                w_pop;

  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [0:DATA_W-1]   w_head;
  logic [D0W-1:0]      w_dest0;
  logic [D1W-1:0]      w_dest1;

  fb_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (valid_i),
    .i_data        (data_i),
    .i_pop         (w_pop),
    .o_full_c      (w_full),
    .o_empty_c     (w_empty),
    .o_count_nxt_c (w_count_nxt),
    .o_head        (w_head)
  );

  // Route of the flit currently at the buffer head.
  assign w_dest0      = w_head[DEST_OFS +: D0W];
  assign w_dest1      = w_head[DEST_OFS + D0W +: D1W];
  assign w_route_calc = ROUTE_W'(fb_port_idx(32'(w_dest0), 32'(w_dest1),
                                             curr_dim0, curr_dim1,
                                             NODE_PER_ROW, NODE_PER_COL));

  // Packet FSM: latch route on a head, forward on grant until the tail leaves.
  always_comb begin
    w_state_nxt = r_state;
    w_route_nxt = r_route;
    w_pop       = 1'b0;
    w_perr_nxt  = r_perr;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (w_head[HEAD_BIT]) begin
            w_route_nxt = w_route_calc;
            w_state_nxt = ST_ACTIVE;
          end else begin
            w_pop      = 1'b1;
            w_perr_nxt = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        // A non-zero request implies a non-empty buffer.
        if (grant_i && (r_req != '0)) begin
          w_pop = 1'b1;
          if (w_head[TAIL_BIT]) begin
            w_state_nxt = ST_IDLE;
            w_route_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_route_nxt = '0;
      end
    endcase
  end

  // Registered outputs, all derived from the post-push/pop occupancy.
  always_comb begin
    w_req_nxt = '0;
    w_off_nxt = r_off;
    w_ovf_nxt = r_ovf;
    if ((w_state_nxt == ST_ACTIVE) && (w_count_nxt != '0)) begin
      w_req_nxt[w_route_nxt] = 1'b1;
    end
    if (w_count_nxt >= CNT_W'(OFF_THRESH)) begin
      w_off_nxt = 1'b1;
    end else if (w_count_nxt <= CNT_W'(ON_THRESH)) begin
      w_off_nxt = 1'b0;
    end
    if (valid_i && w_full && !w_pop) begin
      w_ovf_nxt = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_route <= '0;
      r_req   <= '0;
      r_off   <= 1'b0;
      r_ovf   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_route <= w_route_nxt;
      r_req   <= w_req_nxt;
      r_off   <= w_off_nxt;
      r_ovf   <= w_ovf_nxt;
      r_perr  <= w_perr_nxt;
    end
  end

  assign off_o       = r_off;
  assign req_o       = r_req;
  assign flit_o      = w_head;
  assign overflow_o  = r_ovf;
  assign proto_err_o = r_perr;

endmodule

// File: tb/tb_fb_input_unit.sv
// tb_fb_input_unit: scoreboard bench for fb_input_unit at router (1,2).
module tb_fb_input_unit;

  localparam int DATA_W  = 16;
  localparam int NPR     = 4;
  localparam int NPC     = 4;
  localparam int CD0     = 1;
  localparam int CD1     = 2;
  localparam int OUTPORT = NPR + NPC - 1;
  localparam int OFF_TH  = 6;
  localparam int ON_TH   = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                valid_i;
  logic [0:DATA_W-1]   data_i;
  logic                off_o;
  logic [0:OUTPORT-1]  req_o;
  logic [0:DATA_W-1]   flit_o;
  logic                grant_i;
  logic                overflow_o;
  logic                proto_err_o;

  typedef struct {
    logic [0:DATA_W-1] flit;
    int                port;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   delivered = 0;
  bit   rand_done = 0;

  always #5 clk = ~clk;

  fb_input_unit #(
    .DATA_W(16), .FIFO_DEPTH(8), .OFF_THRESH(6), .ON_THRESH(3),
    .NODE_PER_ROW(4), .NODE_PER_COL(4), .curr_dim0(1), .curr_dim1(2)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .off_o(off_o),
    .req_o(req_o), .flit_o(flit_o), .grant_i(grant_i),
    .overflow_o(overflow_o), .proto_err_o(proto_err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Dimension-order routing rule, straight from the port numbering.
  function automatic int exp_port(input int d0, input int d1);
    if (d0 != CD0) return (d0 < CD0) ? d0 : d0 - 1;
    if (d1 != CD1) return (d1 < CD1) ? d1 + NPR - 1 : d1 + NPR - 2;
    return OUTPORT - 1;
  endfunction

  function automatic logic [0:OUTPORT-1] onehot(input int p);
    logic [0:OUTPORT-1] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:DATA_W-1] mk_flit(input bit h, input bit t, input int d0, input int d1);
    logic [0:DATA_W-1] f;
    f = 16'($urandom);
    f[0] = h;
    f[1] = t;
    if (h) begin
      f[2 +: 2] = 2'(d0);
      f[4 +: 2] = 2'(d1);
    end
    return f;
  endfunction

  task automatic expect_flit(input logic [0:DATA_W-1] f, input int p);
    exp_t e;
    e.flit = f;
    e.port = p;
    exp_q.push_back(e);
  endtask

  // Monitor: every granted request must match the next expected flit.
  always @(negedge clk) begin
    if (!rst && grant_i && (req_o != '0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual_req=%b required=no_request", req_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_flit", 32'(flit_o), 32'(mon_e.flit));
        check("sb_req", 32'(req_o), 32'(onehot(mon_e.port)));
        delivered++;
      end
    end
  end

  task automatic route_single(input int d0, input int d1);
    logic [0:DATA_W-1] f;
    int p;
    p = exp_port(d0, d1);
    f = mk_flit(1'b1, 1'b1, d0, d1);
    expect_flit(f, p);
    @(posedge clk); #1; valid_i = 1'b1; data_i = f;
    @(posedge clk); #1; valid_i = 1'b0;
    @(negedge clk); check("lat1_req", 32'(req_o), 32'd0);
    @(negedge clk); check("route_req", 32'(req_o), 32'(onehot(p)));
    @(posedge clk); #1; grant_i = 1'b1;
    @(posedge clk); #1; grant_i = 1'b0;
    @(negedge clk); check("route_idle", 32'(req_o), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1; valid_i = 1'b0; grant_i = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_flit", 32'(flit_o), 32'd0);
    check("rst_off", 32'(off_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_perr", 32'(proto_err_o), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [0:DATA_W-1] pkt[10];
    logic [0:OUTPORT-1] trace[10];
    logic [0:OUTPORT-1] want[10];
    int occ;
    bit moff;
    int d_start;
    int p;
    int d0s[4] = '{3, 1, 1, 1};
    int d1s[4] = '{0, 0, 3, 2};

    rst = 1'b1; valid_i = 1'b0; grant_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Route table for the four test-plan destinations.
    for (int k = 0; k < 4; k++) route_single(d0s[k], d1s[k]);

    // Four-flit packet then single flit under continuous grant.
    p = exp_port(0, 2);
    pkt[0] = mk_flit(1'b1, 1'b0, 0, 2);
    pkt[1] = mk_flit(1'b0, 1'b0, 0, 0);
    pkt[2] = mk_flit(1'b0, 1'b0, 0, 0);
    pkt[3] = mk_flit(1'b0, 1'b1, 0, 0);
    pkt[4] = mk_flit(1'b1, 1'b1, 1, 3);
    for (int i = 0; i < 4; i++) expect_flit(pkt[i], p);
    expect_flit(pkt[4], exp_port(1, 3));
    for (int i = 0; i < 10; i++) want[i] = '0;
    for (int i = 2; i < 6; i++) want[i] = onehot(p);
    want[7] = onehot(exp_port(1, 3));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) grant_i = 1'b1;
      if (i < 5) begin valid_i = 1'b1; data_i = pkt[i]; end
      else valid_i = 1'b0;
      @(negedge clk); trace[i] = req_o;
    end
    for (int i = 0; i < 10; i++) check($sformatf("burst_req%0d", i), 32'(trace[i]), 32'(want[i]));
    @(posedge clk); #1; grant_i = 1'b0;

    // Hysteresis: fill to 7 with no grant, then drain.
    p = exp_port(2, 1);
    occ = 0; moff = 0;
    for (int i = 0; i < 7; i++) begin
      pkt[i] = mk_flit(i == 0, i == 6, 2, 1);
      expect_flit(pkt[i], p);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        occ++;
        if (occ >= OFF_TH) moff = 1; else if (occ <= ON_TH) moff = 0;
        check($sformatf("off_fill%0d", occ), 32'(off_o), 32'(moff));
      end
      if (i < 7) begin valid_i = 1'b1; data_i = pkt[i]; end
      else begin valid_i = 1'b0; grant_i = 1'b1; end
    end
    for (int j = 0; j < 7; j++) begin
      @(posedge clk); #1;
      occ--;
      if (occ >= OFF_TH) moff = 1; else if (occ <= ON_TH) moff = 0;
      check($sformatf("off_drain%0d", occ), 32'(off_o), 32'(moff));
      if (j == 6) grant_i = 1'b0;
    end

    // Overflow: 9 back-to-back flits, then push+pop at full.
    d_start = delivered;
    p = exp_port(1, 0);
    for (int i = 0; i < 8; i++) begin
      pkt[i] = mk_flit(i == 0, i == 7, 1, 0);
      expect_flit(pkt[i], p);
    end
    pkt[8] = mk_flit(1'b1, 1'b1, 3, 0);
    pkt[9] = mk_flit(1'b1, 1'b1, 0, 0);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      if (i == 8) check("ovf_before", 32'(overflow_o), 32'd0);
      if (i == 9) begin
        check("ovf_set", 32'(overflow_o), 32'd1);
        check("ovf_off", 32'(off_o), 32'd1);
        expect_flit(pkt[9], exp_port(0, 0));
        grant_i = 1'b1;
      end
      if (i < 10) begin valid_i = 1'b1; data_i = pkt[i]; end
      else valid_i = 1'b0;
    end
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    grant_i = 1'b0;
    check("ovf_drain_left", 32'(exp_q.size()), 32'd0);
    check("ovf_delivered", 32'(delivered - d_start), 32'd9);
    check("ovf_sticky", 32'(overflow_o), 32'd1);

    // Protocol error: stray body flit while idle.
    do_reset();
    @(posedge clk); #1; valid_i = 1'b1; data_i = mk_flit(1'b0, 1'b0, 0, 0);
    @(posedge clk); #1; valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("perr_req", 32'(req_o), 32'd0);
    end
    check("perr_set", 32'(proto_err_o), 32'd1);
    route_single(1, 2);
    check("perr_sticky", 32'(proto_err_o), 32'd1);

    // Reset in the middle of a packet.
    @(posedge clk); #1; valid_i = 1'b1; data_i = mk_flit(1'b1, 1'b0, 3, 3);
    @(posedge clk); #1; data_i = mk_flit(1'b0, 1'b0, 0, 0);
    @(posedge clk); #1; valid_i = 1'b0;
    @(negedge clk); check("mid_req", 32'(req_o), 32'(onehot(exp_port(3, 3))));
    do_reset();
    route_single(1, 0);

    // Randomized traffic respecting off_o, with random grants.
    d_start = delivered;
    p = 0;
    fork
      begin
        int guard;
        int len, a, b;
        guard = 0;
        for (int pk = 0; pk < 40 && guard < 20000; pk++) begin
          len = $urandom_range(1, 5);
          a = $urandom_range(0, 3);
          b = $urandom_range(0, 3);
          for (int f = 0; f < len && guard < 20000; ) begin
            @(posedge clk); #1;
            guard++;
            if (!off_o && ($urandom_range(0, 3) != 0)) begin
              valid_i = 1'b1;
              data_i = mk_flit(f == 0, f == len - 1, a, b);
              expect_flit(data_i, exp_port(a, b));
              p++;
              f++;
            end else begin
              valid_i = 1'b0;
            end
          end
        end
        @(posedge clk); #1; valid_i = 1'b0;
        if (guard >= 20000) begin
          checks++;
          failures++;
          $display("FAIL rand_timeout actual=%0d required=<20000", guard);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          grant_i = 1'($urandom_range(0, 1));
        end
      end
    join
    grant_i = 1'b1;
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    grant_i = 1'b0;
    check("rand_drain_left", 32'(exp_q.size()), 32'd0);
    check("rand_delivered", 32'(delivered - d_start), 32'(p));
    check("rand_ovf", 32'(overflow_o), 32'd0);
    check("rand_perr", 32'(proto_err_o), 32'd0);
    repeat (2) @(negedge clk);
    check("final_req", 32'(req_o), 32'd0);
    check("final_off", 32'(off_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
